apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
Single-outstanding APB initiator. It converts a req/gnt/rvalid request interface, as driven by the core's peripheral port, into APB SETUP/ACCESS transfers. It drives the peripheral side of the APB bus, including the SoC control/pad register block. It also adds a wait-state timeout so that a hung slave cannot stall the requester.

Parameters:
APB_ADDR_WIDTH, 12, width of PADDR and addr_i (4KB slave window).
TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before the transfer is aborted with an error; 0 disables the timeout.

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
req_i  in  1  request valid
addr_i  in  APB_ADDR_WIDTH  byte address
we_i  in  1  1=write, 0=read
wdata_i  in  32  write data
gnt_o  out  1  request accepted
rvalid_o  out  1  response valid, one-cycle pulse
rdata_o  out  32  read data, valid with rvalid_o
err_o  out  1  slave error or timeout, valid with rvalid_o
PADDR  out  APB_ADDR_WIDTH  APB address
PWDATA  out  32  APB write data
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PRDATA  in  32  APB read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESETn is asynchronous and active-low.
- Reset values: every output is 0. State is IDLE. The wait counter is 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - gnt_o = req_i (combinational); gnt_o is 0 in all other states.
  - When req_i=1, register {addr_i[AW-1:2], 2'b00}, we_i and wdata_i into PADDR/PWRITE/PWDATA, then go to SETUP.
  - When req_i=0, hold all outputs.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS. Clear the wait counter.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: register rdata_o = PWRITE ? 0 : PRDATA and err_o = PSLVERR, then go to RESP.
  - PREADY=0: increment the counter.
  - Timeout: if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with PREADY=0, register rdata_o=0 and err_o=1, then go to RESP.
  - PREADY=1 on the timeout cycle takes priority over the timeout; this is a normal completion.
- RESP: rvalid_o=1 for one cycle, PSEL=PENABLE=0, then go to IDLE. rdata_o and err_o hold until the next response.
- Bus stability: PADDR, PWRITE and PWDATA stay stable from SETUP through the last ACCESS cycle. They hold their last values while idle. PENABLE is never 1 without PSEL.
- Latency: grant in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rvalid_o in cycle 3 with zero wait states. Each wait state adds 1 cycle.
- Back-to-back throughput is at most one transfer per 4 cycles. A req_i held high during RESP is granted in the following IDLE cycle.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it never wraps because it clears in SETUP.
- Reset asserted mid-transfer: PSEL/PENABLE drop immediately (asynchronously). No rvalid_o is produced for the aborted request.
- Requester rules: the requester never drops req_i before gnt_o, and must accept rvalid_o unconditionally (there is no backpressure).

Decomposition:
- apb_master_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_e
  - localparam TIMEOUT_RDATA = 32'h0
- Single module; the timeout counter is inline, and no sub-module is warranted.

Test Plan:
- Zero-wait write: req addr=0x008, we=1, wdata=0x0000_0080, PREADY=1. Required: PSEL=1 in cycle 1, PENABLE=1 in cycle 2 with PADDR=0x008 and PWDATA=0x80, rvalid_o in cycle 3 with err_o=0.
- Wait-state read: addr=0x010, slave holds PREADY=0 for 3 ACCESS cycles, then PREADY=1 with PRDATA=0x0004_0402. Required: PADDR stable throughout, rvalid_o 6 cycles after grant, rdata_o=0x0004_0402, err_o=0.
- Slave error: read with PREADY=1, PSLVERR=1, PRDATA=0xFFFF_FFFF. Required: rvalid_o=1, err_o=1, rdata_o=0xFFFF_FFFF.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0. Required: exactly 4 ACCESS cycles, then rvalid_o=1, err_o=1, rdata_o=0, and PSEL low in the RESP cycle. Repeat with PREADY=1 in the 4th cycle: err_o=0.
- Back-to-back: req_i held high for a write to 0x000 then a read from 0x014, PREADY=1. Required: second gnt_o 4 cycles after the first, and no cycle with PENABLE=1 and PSEL=0.
- Reset mid-ACCESS: assert HRESETn=0 during ACCESS. Required: PSEL, PENABLE, gnt_o and rvalid_o all 0 immediately. After release, the FSM is in IDLE and a new request completes normally.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB initiator bridge.
package apb_master_pkg;

    // Bridge sequencing: one outstanding transfer, walked through the APB phases.
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_mst_state_e;

    // Read data returned when a transfer is abandoned by the wait-state timeout.
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: turns a req/gnt/rvalid request port into
// APB SETUP/ACCESS transfers, with an optional wait-state timeout so a hung
// slave cannot stall the requester forever.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    // requester side
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [31:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    // APB side
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int AW = APB_ADDR_WIDTH;
    // Keep a 1-bit counter when the timeout is disabled so the declaration stays legal.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    // APB transfers are word-aligned; the byte-offset bits are forced to zero.
    localparam logic [AW-1:0] ADDR_MASK = {{(AW-2){1'b1}}, 2'b00};

    apb_mst_state_e state;
    logic [CW-1:0]  wait_cnt;
    logic           timeout_hit;

    // Last ACCESS cycle the slave is allowed before the transfer is abandoned.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

    // Grant is combinational in IDLE; gated by reset so it drops the moment reset asserts.
    assign gnt_o = HRESETn && req_i && (state == IDLE);

    // Transfer sequencer; all bus and response outputs are registered here.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            PADDR    <= '0;
            PWDATA   <= '0;
            PWRITE   <= 1'b0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Bus signals only change on acceptance; otherwise they hold.
                    if (req_i) begin
                        PADDR  <= addr_i & ADDR_MASK;
                        PWRITE <= we_i;
                        PWDATA <= wdata_i;
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over a timeout landing on the same cycle.
                    if (PREADY) begin
                        PSEL     <= 1'b0;
                        PENABLE  <= 1'b0;
                        rvalid_o <= 1'b1;
                        rdata_o  <= PWRITE ? 32'h0 : PRDATA;
                        err_o    <= PSLVERR;
                        state    <= RESP;
                    end else if (timeout_hit) begin
                        PSEL     <= 1'b0;
                        PENABLE  <= 1'b0;
                        rvalid_o <= 1'b1;
                        rdata_o  <= TIMEOUT_RDATA;
                        err_o    <= 1'b1;
                        state    <= RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    // rdata_o/err_o keep their value until the next response.
                    rvalid_o <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: each accepted request pushes its
// expected bus view and response; a negedge monitor checks the bus and pops
// on rvalid_o.
module tb_apb_master_bridge;

    localparam int TO = 4;

    logic        HCLK, HRESETn;
    logic        req_i, we_i;
    logic [11:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    apb_master_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          acc;
    } txn_t;

    txn_t q[$];
    int n_chk = 0, n_err = 0;
    int cyc = 0;
    int macc = 0;

    // slave model: ready after slv_wait wait states
    int          slv_wait = 0;
    int          acc_cnt = 0;
    logic [31:0] slv_rdata = 32'h0;
    logic        slv_err = 1'b0;

    assign PREADY  = PSEL && PENABLE && (acc_cnt == slv_wait);
    assign PRDATA  = slv_rdata;
    assign PSLVERR = slv_err && PREADY;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    always @(posedge HCLK) begin
        cyc     <= cyc + 1;
        acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Bus and response monitor
    always @(negedge HCLK) begin
        txn_t t;
        if (!HRESETn) begin
            macc = 0;
        end else begin
            chk("penable_without_psel", 32'(PENABLE & ~PSEL), 32'h0);
            if (PSEL) begin
                if (q.size() == 0) chk("psel_unexpected", 32'(PSEL), 32'h0);
                else begin
                    chk("paddr", 32'(PADDR), 32'(q[0].addr));
                    chk("pwrite", 32'(PWRITE), 32'(q[0].we));
                    if (q[0].we) chk("pwdata", PWDATA, q[0].wdata);
                end
                if (PENABLE) macc++;
            end
            if (rvalid_o) begin
                if (q.size() == 0) chk("rvalid_unexpected", 32'(rvalid_o), 32'h0);
                else begin
                    t = q.pop_front();
                    chk("rdata", rdata_o, t.rdata);
                    chk("err", 32'(err_o), 32'(t.err));
                    chk("rvalid_cycle", 32'(cyc), 32'(t.cyc));
                    chk("access_cycles", 32'(macc), 32'(t.acc));
                    chk("psel_in_resp", 32'(PSEL | PENABLE), 32'h0);
                end
                macc = 0;
            end
        end
    end

    // Present a request, wait for its grant, push the expected result.
    // Returns one cycle after the grant edge with req_i still high.
    task automatic issue(input logic [11:0] a, input logic we, input logic [31:0] wd,
                         input int wt, input logic [31:0] rd, input logic se, output int gcyc);
        txn_t t;
        int n;
        slv_wait  = wt;
        slv_rdata = rd;
        slv_err   = se;
        addr_i = a; we_i = we; wdata_i = wd; req_i = 1'b1;
        t.addr  = a & 12'hFFC;
        t.we    = we;
        t.wdata = wd;
        t.acc   = (wt < TO) ? wt + 1 : TO;
        t.err   = (wt < TO) ? se : 1'b1;
        t.rdata = (wt >= TO || we) ? 32'h0 : rd;
        n = 0;
        gcyc = -1;
        do begin
            @(negedge HCLK);
            n++;
        end while (!gnt_o && n < 50);
        if (!gnt_o) chk("gnt_timeout", 32'(gnt_o), 32'h1);
        else begin
            gcyc  = cyc;
            t.cyc = cyc + 2 + t.acc;
            q.push_back(t);
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'h0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic single(input logic [11:0] a, input logic we, input logic [31:0] wd,
                          input int wt, input logic [31:0] rd, input logic se);
        int g;
        issue(a, we, wd, wt, rd, se, g);
        req_i = 1'b0;
        drain();
    endtask

    initial begin
        int g1, g2;
        HRESETn = 1'b0;
        req_i = 1'b1; addr_i = 12'h0; we_i = 1'b0; wdata_i = 32'h0;
        #3;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_psel_pen", 32'({PSEL, PENABLE}), 32'h0);
        chk("rst_resp", 32'({rvalid_o, err_o}), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_bus", 32'({PADDR, PWRITE}), 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        req_i = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // zero-wait write, wait-state read, slave error, misaligned address
        single(12'h008, 1'b1, 32'h0000_0080, 0, 32'h0, 1'b0);
        single(12'h010, 1'b0, 32'h0, 3, 32'h0004_0402, 1'b0);
        single(12'h020, 1'b0, 32'h0, 0, 32'hFFFF_FFFF, 1'b1);
        single(12'h7FF, 1'b1, 32'hDEAD_BEEF, 1, 32'h1234_5678, 1'b0);

        // timeout, and ready arriving exactly on the timeout cycle
        single(12'h030, 1'b0, 32'h0, 100, 32'hAAAA_5555, 1'b0);
        single(12'h034, 1'b0, 32'h0, TO - 1, 32'h5555_AAAA, 1'b0);
        single(12'h038, 1'b1, 32'h0000_0001, 100, 32'h0, 1'b0);

        // back-to-back with req_i held high
        issue(12'h000, 1'b1, 32'hCAFE_0001, 0, 32'h0BAD_F00D, 1'b0, g1);
        issue(12'h014, 1'b0, 32'h0, 0, 32'h0BAD_F00D, 1'b0, g2);
        req_i = 1'b0;
        chk("b2b_gnt_gap", 32'(g2 - g1), 32'h4);
        drain();

        // reset during ACCESS with a request still pending
        issue(12'h040, 1'b0, 32'h0, 100, 32'h0, 1'b0, g1);
        @(negedge HCLK);
        @(negedge HCLK);
        chk("pre_rst_access", 32'({PSEL, PENABLE}), 32'h3);
        #2 HRESETn = 1'b0;
        #1;
        chk("midrst_psel_pen", 32'({PSEL, PENABLE}), 32'h0);
        chk("midrst_gnt", 32'(gnt_o), 32'h0);
        chk("midrst_rvalid", 32'(rvalid_o), 32'h0);
        q.delete();
        @(posedge HCLK);
        #1 req_i = 1'b0;
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);
        chk("post_rst_idle", 32'({PSEL, PENABLE, rvalid_o}), 32'h0);
        @(posedge HCLK);
        #1;
        single(12'h044, 1'b0, 32'h0, 2, 32'h1357_9BDF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
